// File: rtl/load_store_unit_if.sv
// Bundles the CPU request/response channel and the word-wide data memory port of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment (CPU plus memory).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_load_data;
    logic        mem_req;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_address, req_store_data, mem_read_data,
        output req_ready, resp_valid, resp_error, resp_load_data,
        output mem_req, mem_write_enable, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_address, req_store_data, mem_read_data,
        input  req_ready, resp_valid, resp_error, resp_load_data,
        input  mem_req, mem_write_enable, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store engine over a word-only memory with one-cycle registered read.
// Byte and halfword stores are done as read-merge-write; illegal accesses respond with an error and no memory traffic.
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, LOAD_RESP, RESP} state_t;

    state_t      state_q;
    logic        isStore_q;
    logic [2:0]  funct3_q;
    logic [31:0] address_q;
    logic [15:0] storeLow_q;

    logic        reqReady_q;
    logic        respValid_q;
    logic        respError_q;
    logic [31:0] respLoadData_q;
    logic        memReq_q;
    logic        memWriteEnable_q;
    logic [31:0] memAddress_q;
    logic [31:0] memWriteData_q;

    logic        accessLegal_d;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData_d;
    logic [31:0] mergedWord_d;

    // Alignment by access size, then the funct3 codes that exist only for loads (unsigned) are rejected for stores.
    always_comb begin
        accessLegal_d = 1'b0;
        case (bus.req_funct3[1:0])
            2'b00:   accessLegal_d = 1'b1;
            2'b01:   accessLegal_d = ~bus.req_address[0];
            2'b10:   accessLegal_d = (bus.req_address[1:0] == 2'b00);
            default: accessLegal_d = 1'b0;
        endcase
        if (bus.req_is_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b110))
            accessLegal_d = 1'b0;
    end

    always_comb begin
        loadByte = bus.mem_read_data[{address_q[1:0], 3'b000} +: 8];
        loadHalf = bus.mem_read_data[{address_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  loadData_d = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData_d = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData_d = {24'd0, loadByte};
            3'b101:  loadData_d = {16'd0, loadHalf};
            default: loadData_d = bus.mem_read_data;
        endcase
        mergedWord_d = bus.mem_read_data;
        if (funct3_q[1:0] == 2'b00)
            mergedWord_d[{address_q[1:0], 3'b000} +: 8] = storeLow_q[7:0];
        else
            mergedWord_d[{address_q[1], 4'b0000} +: 16] = storeLow_q;
    end

    // Memory and response outputs default low each cycle, so every pulse lasts exactly one state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            isStore_q        <= 1'b0;
            funct3_q         <= 3'd0;
            address_q        <= 32'd0;
            storeLow_q       <= 16'd0;
            reqReady_q       <= 1'b1;
            respValid_q      <= 1'b0;
            respError_q      <= 1'b0;
            respLoadData_q   <= 32'd0;
            memReq_q         <= 1'b0;
            memWriteEnable_q <= 1'b0;
            memAddress_q     <= 32'd0;
            memWriteData_q   <= 32'd0;
        end else begin
            respValid_q      <= 1'b0;
            respError_q      <= 1'b0;
            respLoadData_q   <= 32'd0;
            memReq_q         <= 1'b0;
            memWriteEnable_q <= 1'b0;
            memAddress_q     <= 32'd0;
            memWriteData_q   <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && reqReady_q) begin
                        reqReady_q <= 1'b0;
                        isStore_q  <= bus.req_is_store;
                        funct3_q   <= bus.req_funct3;
                        address_q  <= bus.req_address;
                        storeLow_q <= bus.req_store_data[15:0];
                        if (!accessLegal_d) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respError_q <= 1'b1;
                        end else if (bus.req_is_store && (bus.req_funct3[1:0] == 2'b10)) begin
                            state_q          <= WRITE;
                            memReq_q         <= 1'b1;
                            memWriteEnable_q <= 1'b1;
                            memAddress_q     <= {bus.req_address[31:2], 2'b00};
                            memWriteData_q   <= bus.req_store_data;
                        end else begin
                            state_q      <= READ;
                            memReq_q     <= 1'b1;
                            memAddress_q <= {bus.req_address[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    state_q <= isStore_q ? MERGE : LOAD_RESP;
                end
                MERGE: begin
                    state_q          <= WRITE;
                    memReq_q         <= 1'b1;
                    memWriteEnable_q <= 1'b1;
                    memAddress_q     <= {address_q[31:2], 2'b00};
                    memWriteData_q   <= mergedWord_d;
                end
                WRITE: begin
                    state_q     <= RESP;
                    respValid_q <= 1'b1;
                end
                LOAD_RESP: begin
                    state_q        <= RESP;
                    respValid_q    <= 1'b1;
                    respLoadData_q <= loadData_d;
                end
                RESP: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready        = reqReady_q;
    assign bus.resp_valid       = respValid_q;
    assign bus.resp_error       = respError_q;
    assign bus.resp_load_data   = respLoadData_q;
    assign bus.mem_req          = memReq_q;
    assign bus.mem_write_enable = memWriteEnable_q;
    assign bus.mem_address      = memAddress_q;
    assign bus.mem_write_data   = memWriteData_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses against a byte-level memory model.
// A word memory with one-cycle registered read sits behind the DUT; expectations come from the byte model only.
module tb_load_store_unit;
   logic clk;
   logic reset;
   load_store_unit_if bus ();

   load_store_unit dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [31:0] memWords [64];
   logic [7:0]  refMem   [256];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   logic [31:0] lastRespData;
   logic        lastRespErr;

   bit          chainPending = 0;
   bit          chainIsStore;
   logic [2:0]  chainF3;
   logic [31:0] chainAddr;
   logic [31:0] chainData;

   // Clock: 10 time-unit period, active edge is posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory seen by the DUT: writes land at the edge, reads appear the cycle after the request.
   always @(posedge clk) begin
      if (bus.mem_req) begin
         if (bus.mem_write_enable)
            memWords[bus.mem_address[7:2]] <= bus.mem_write_data;
         else
            bus.mem_read_data <= memWords[bus.mem_address[7:2]];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] refWord(input int base);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < 4; i++)
         w = w | (32'(refMem[base + i]) << (8 * i));
      return w;
   endfunction

   // Issues one request, predicts its outcome from the byte model and checks timing, traffic and response.
   task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input bit keepValid);
      int          nBytes;
      bit          legal;
      int          expLat;
      int          expRead;
      int          expWrite;
      logic [31:0] expData;
      logic [31:0] expWord;
      int          a;
      int          waited;
      bit          done;
      int          respCycle;
      int          readCycle;
      int          writeCycle;
      int          extraMem;
      int          readyHigh;
      logic [31:0] rAddr;
      logic [31:0] wAddr;
      logic [31:0] wData;

      nBytes  = 1 << f3[1:0];
      a       = int'(addr[7:0]);
      legal   = (f3[1:0] != 2'b11) && ((a % nBytes) == 0) && (isStore ? !f3[2] : (f3 != 3'b110));
      expData = 32'd0;
      expWord = 32'd0;
      if (!legal) begin
         expLat = 1; expRead = 0; expWrite = 0;
      end else if (isStore) begin
         expLat   = (nBytes == 4) ? 2 : 4;
         expRead  = (nBytes == 4) ? 0 : 1;
         expWrite = (nBytes == 4) ? 1 : 3;
         for (int i = 0; i < nBytes; i++)
            refMem[a + i] = 8'(sdata >> (8 * i));
         expWord = refWord(a & ~3);
      end else begin
         expLat = 3; expRead = 1; expWrite = 0;
         for (int i = 0; i < nBytes; i++)
            expData = expData | (32'(refMem[a + i]) << (8 * i));
         if (!f3[2] && nBytes < 4 && expData[8 * nBytes - 1])
            expData = expData | ~((32'd1 << (8 * nBytes)) - 32'd1);
      end

      bus.req_valid      = 1'b1;
      bus.req_is_store   = isStore;
      bus.req_funct3     = f3;
      bus.req_address    = addr;
      bus.req_store_data = sdata;
      waited = 0;
      while (!bus.req_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      checkOutput("acceptWait", 32'(waited), 32'd0);

      done = 0; respCycle = 0; readCycle = 0; writeCycle = 0; extraMem = 0; readyHigh = 0;
      rAddr = 32'd0; wAddr = 32'd0; wData = 32'd0;
      for (int k = 1; k <= 8 && !done; k++) begin
         @(negedge clk);
         if (k == 1 && !keepValid) begin
            bus.req_valid      = 1'b0;
            bus.req_is_store   = 1'($urandom);
            bus.req_funct3     = 3'($urandom);
            bus.req_address    = $urandom;
            bus.req_store_data = $urandom;
         end
         if (bus.mem_req) begin
            if (bus.mem_write_enable && writeCycle == 0) begin
               writeCycle = k; wAddr = bus.mem_address; wData = bus.mem_write_data;
            end else if (!bus.mem_write_enable && readCycle == 0) begin
               readCycle = k; rAddr = bus.mem_address;
            end else begin
               extraMem++;
            end
         end
         if (bus.req_ready) readyHigh++;
         if (bus.resp_valid) begin
            done         = 1;
            respCycle    = k;
            lastRespErr  = bus.resp_error;
            lastRespData = bus.resp_load_data;
            if (keepValid && chainPending) begin
               bus.req_is_store   = chainIsStore;
               bus.req_funct3     = chainF3;
               bus.req_address    = chainAddr;
               bus.req_store_data = chainData;
            end
         end
      end
      if (!done) begin
         checkOutput("respTimeout", 32'd0, 32'd1);
         return;
      end
      checkOutput("respLatency", 32'(respCycle), 32'(expLat));
      checkOutput("respError", 32'(lastRespErr), 32'(!legal));
      checkOutput("respData", lastRespData, expData);
      checkOutput("readCycle", 32'(readCycle), 32'(expRead));
      checkOutput("writeCycle", 32'(writeCycle), 32'(expWrite));
      checkOutput("extraMemCycles", 32'(extraMem), 32'd0);
      checkOutput("readyDuringOp", 32'(readyHigh), 32'd0);
      if (expRead != 0) checkOutput("readAddress", rAddr, {addr[31:2], 2'b00});
      if (expWrite != 0) begin
         checkOutput("writeAddress", wAddr, {addr[31:2], 2'b00});
         checkOutput("writeData", wData, expWord);
      end
      @(negedge clk);
      checkOutput("respPulseEnds", 32'(bus.resp_valid), 32'd0);
      checkOutput("readyAfterResp", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] w;
      int          memSeen;
      bit          rs;
      logic [2:0]  rf3;
      logic [31:0] raddr;

      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if (i == 1) w = 32'h11223344;
         if (i == 2) w = 32'hDEADBEEF;
         memWords[i] = w;
         for (int b = 0; b < 4; b++) refMem[4 * i + b] = 8'(w >> (8 * b));
      end
      bus.mem_read_data  = 32'd0;
      bus.req_valid      = 1'b0;
      bus.req_is_store   = 1'b0;
      bus.req_funct3     = 3'd0;
      bus.req_address    = 32'd0;
      bus.req_store_data = 32'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetReady", 32'(bus.req_ready), 32'd1);
      checkOutput("resetRespValid", 32'(bus.resp_valid), 32'd0);
      checkOutput("resetMemReq", 32'(bus.mem_req), 32'd0);
      checkOutput("resetMemAddress", bus.mem_address, 32'd0);
      checkOutput("resetLoadData", bus.resp_load_data, 32'd0);

      $display("[TB] directed loads and stores");
      applyStimulus(1'b0, 3'b010, 32'h08, 32'd0, 1'b0);
      checkOutput("lwDeadbeef", lastRespData, 32'hDEADBEEF);
      applyStimulus(1'b1, 3'b010, 32'h08, 32'h80FF1234, 1'b0);
      applyStimulus(1'b0, 3'b000, 32'h0B, 32'd0, 1'b0);
      checkOutput("lbSignExt", lastRespData, 32'hFFFFFF80);
      applyStimulus(1'b0, 3'b100, 32'h0B, 32'd0, 1'b0);
      checkOutput("lbuZeroExt", lastRespData, 32'h00000080);
      applyStimulus(1'b0, 3'b101, 32'h0A, 32'd0, 1'b0);
      checkOutput("lhuZeroExt", lastRespData, 32'h000080FF);
      applyStimulus(1'b1, 3'b000, 32'h05, 32'h000000AB, 1'b0);
      applyStimulus(1'b1, 3'b001, 32'h03, 32'h12345678, 1'b0);
      checkOutput("shMisalignedErr", 32'(lastRespErr), 32'd1);
      applyStimulus(1'b0, 3'b010, 32'h02, 32'd0, 1'b0);
      checkOutput("lwMisalignedData", lastRespData, 32'd0);

      $display("[TB] reset during merge");
      bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'b000;
      bus.req_address = 32'h05; bus.req_store_data = 32'h000000CD;
      @(negedge clk);
      bus.req_valid = 1'b0;
      checkOutput("rmwReadIssued", 32'(bus.mem_req), 32'd1);
      @(negedge clk);
      checkOutput("rmwMergeNoReq", 32'(bus.mem_req), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("postResetReady", 32'(bus.req_ready), 32'd1);
      checkOutput("postResetRespValid", 32'(bus.resp_valid), 32'd0);
      memSeen = 0;
      for (int k = 0; k < 5; k++) begin
         if (bus.mem_req) memSeen++;
         @(negedge clk);
      end
      checkOutput("postResetNoMemTraffic", 32'(memSeen), 32'd0);
      applyStimulus(1'b0, 3'b010, 32'h04, 32'd0, 1'b0);
      checkOutput("rmwAbandoned", lastRespData, 32'h1122AB44);

      $display("[TB] back-to-back with valid held");
      chainPending = 1; chainIsStore = 1'b0; chainF3 = 3'b010; chainAddr = 32'h00; chainData = 32'd0;
      applyStimulus(1'b1, 3'b010, 32'h00, 32'hCAFEF00D, 1'b1);
      chainPending = 0;
      applyStimulus(1'b0, 3'b010, 32'h00, 32'd0, 1'b0);
      checkOutput("b2bLoadValue", lastRespData, 32'hCAFEF00D);

      $display("[TB] random accesses");
      for (int n = 0; n < 60; n++) begin
         rs    = 1'($urandom);
         rf3   = 3'($urandom_range(0, 7));
         raddr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) raddr = raddr & ~((32'd1 << rf3[1:0]) - 32'd1);
         applyStimulus(rs, rf3, raddr, $urandom, 1'b0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
